// File: rtl/rq_gearbox_param.sv
// RQ gearbox: merges a 128-bit request descriptor with a payload stream, shifting
// payload up by four DWs so the header fills the low DWs of the first output beat.
module rq_gearbox_param #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 60,
  parameter int unsigned FBE_LSB    = 0,
  parameter int unsigned LBE_LSB    = 4,
  localparam int unsigned KDW       = DATA_WIDTH / 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [127:0]          rq_descriptor,
  input  logic [DATA_WIDTH-1:0] rq_payload,
  input  logic [10:0]           rq_payload_dw_count,
  input  logic                  rq_payload_sop,
  input  logic                  rq_payload_last,
  input  logic                  rq_valid,
  output logic                  rq_ready,
  output logic [DATA_WIDTH-1:0] s_axis_rq_tdata,
  output logic [KDW-1:0]        s_axis_rq_tkeep,
  output logic [USER_WIDTH-1:0] s_axis_rq_tuser,
  output logic                  s_axis_rq_tlast,
  output logic                  s_axis_rq_tvalid,
  input  logic                  s_axis_rq_tready,
  output logic                  rq_len_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BODY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  localparam int unsigned KLOG     = $clog2(KDW);
  localparam logic [10:0] KMASK    = 11'(KDW - 1);
  localparam logic [10:0] FLUSH_TH = 11'(KDW - 4);
  localparam logic [KDW-1:0] HDR_KEEP = {{(KDW-4){1'b0}}, 4'hF};

  logic [1:0]            r_state;
  logic [127:0]          r_saver;
  logic [10:0]           r_n;
  logic [10:0]           r_cnt;
  logic                  r_drop_pend;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KDW-1:0]        r_tkeep;
  logic [USER_WIDTH-1:0] r_tuser;
  logic                  r_tlast;
  logic                  r_tvalid;
  logic                  r_len_err;

  logic                  w_ld;
  logic                  w_idle;
  logic                  w_n_big;
  logic [10:0]           w_n_in;
  logic [10:0]           w_n;
  logic [10:0]           w_e;
  logic [10:0]           w_tail_r;
  logic [KDW-1:0]        w_tail_keep;
  logic                  w_need_flush;
  logic [10:0]           w_cnt;
  logic                  w_at_e;
  logic                  w_end;
  logic                  w_short;
  logic                  w_over;
  logic                  w_err;
  logic                  w_hdr_only;
  logic [USER_WIDTH-1:0] w_first_user;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic [KDW-1:0]        w_beat_keep;
  logic                  w_beat_last;
  logic [1:0]            w_end_state;

  assign w_ld     = !r_tvalid || s_axis_rq_tready;
  assign rq_ready = w_ld && (r_state != ST_FLUSH);
  assign w_idle   = (r_state == ST_IDLE);

  assign w_n_big  = rq_payload_dw_count > 11'd1024;
  assign w_n_in   = w_n_big ? 11'd1024 : rq_payload_dw_count;
  assign w_n      = w_idle ? w_n_in : r_n;
  assign w_e      = (w_n + KMASK) >> KLOG;

  // The last data beat spills into a flush beat when its top four DWs are occupied.
  assign w_need_flush = ((w_n - 11'd1) & KMASK) >= FLUSH_TH;
  assign w_tail_r     = (w_n + 11'd4) & KMASK;

  always_comb begin
    w_tail_keep = '0;
    for (int unsigned i = 0; i < KDW; i++) begin
      w_tail_keep[i] = (w_tail_r == 11'd0) || (11'(i) < w_tail_r);
    end
  end

  assign w_cnt   = w_idle ? 11'd1 : r_cnt + 11'd1;
  assign w_at_e  = w_cnt >= w_e;
  assign w_end   = w_at_e || rq_payload_last;
  assign w_short = rq_payload_last && !w_at_e;
  assign w_over  = w_at_e && !rq_payload_last;
  assign w_err   = w_short || w_over || (w_idle ? w_n_big : rq_payload_sop);

  assign w_hdr_only = (rq_descriptor[78:75] == 4'b0000) ||
                      (rq_descriptor[78:75] == 4'b0010) ||
                      (rq_payload_dw_count == 11'd0);

  always_comb begin
    w_first_user = '0;
    w_first_user[FBE_LSB +: 4] = rq_descriptor[111:108];
    w_first_user[LBE_LSB +: 4] = (rq_payload_dw_count == 11'd1) ? 4'h0 : rq_descriptor[107:104];
  end

  assign w_beat_data = {rq_payload[DATA_WIDTH-129:0], (w_idle ? rq_descriptor : r_saver)};
  assign w_beat_last = w_end && !w_need_flush;
  assign w_beat_keep = w_beat_last ? w_tail_keep : '1;
  assign w_end_state = w_need_flush ? ST_FLUSH : (w_over ? ST_DROP : ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_saver     <= '0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_drop_pend <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tuser     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_len_err   <= 1'b0;
    end else if (w_ld) begin
      r_tvalid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_BODY: begin
          if (rq_valid) begin
            if (w_idle && !rq_payload_sop) begin
              r_len_err <= 1'b1;
            end else if (w_idle && w_hdr_only) begin
              r_tvalid <= 1'b1;
              r_tdata  <= {{(DATA_WIDTH-128){1'b0}}, rq_descriptor};
              r_tkeep  <= HDR_KEEP;
              r_tuser  <= w_first_user;
              r_tlast  <= 1'b1;
            end else begin
              r_tvalid    <= 1'b1;
              r_tdata     <= w_beat_data;
              r_tkeep     <= w_beat_keep;
              r_tuser     <= w_idle ? w_first_user : '0;
              r_tlast     <= w_beat_last;
              r_saver     <= rq_payload[DATA_WIDTH-1 -: 128];
              r_cnt       <= w_cnt;
              r_state     <= w_end ? w_end_state : ST_BODY;
              // A missing last still needs the flush beat before dropping the excess.
              r_drop_pend <= w_end && w_need_flush && w_over;
              if (w_idle) r_n <= w_n_in;
              if (w_err) r_len_err <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          r_tvalid    <= 1'b1;
          r_tdata     <= {{(DATA_WIDTH-128){1'b0}}, r_saver};
          r_tkeep     <= w_tail_keep;
          r_tuser     <= '0;
          r_tlast     <= 1'b1;
          r_state     <= r_drop_pend ? ST_DROP : ST_IDLE;
          r_drop_pend <= 1'b0;
        end
        default: begin
          if (rq_valid && rq_payload_last) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_axis_rq_tdata  = r_tdata;
  assign s_axis_rq_tkeep  = r_tkeep;
  assign s_axis_rq_tuser  = r_tuser;
  assign s_axis_rq_tlast  = r_tlast;
  assign s_axis_rq_tvalid = r_tvalid;
  assign rq_len_err       = r_len_err;

endmodule

// File: doc/rq_gearbox_param.md
# rq_gearbox_param

Parametrised requester-request (RQ) gearbox between the DMA request engine and the PCIe IP core RQ AXI-Stream port. It merges a 4-DW (128-bit) descriptor with a payload stream, re-aligning payload by 128 bits so the header occupies the low four DWs of the first beat. Supported datapath widths are 256 and 512 bits. It sets per-DW `tkeep`, first/last byte enables in `tuser`, and schedules the trailing flush beat. It fully honours `s_axis_rq_tready` backpressure and detects length/last mismatches.

## Interface
- `DATA_WIDTH`, 256 — datapath width; legal values 256 or 512. `KDW = DATA_WIDTH/32` DWs per beat.
- `USER_WIDTH`, 60 — `s_axis_rq_tuser` width (137 for 512-bit cores).
- `FBE_LSB`, 0 — bit position of the 4-bit first_be field in `tuser`.
- `LBE_LSB`, 4 — bit position of the 4-bit last_be field in `tuser` (8 for 512-bit cores).
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `rq_descriptor`  in  128  — request descriptor; valid on the SOP beat.
- `rq_payload`  in  DATA_WIDTH  — payload beat, DW0 at bit 0.
- `rq_payload_dw_count`  in  11  — payload length N in DWs; sampled only on the SOP beat.
- `rq_payload_sop`, `rq_payload_last`  in  1 each  — first and last payload beat markers.
- `rq_valid`  in  1 / `rq_ready`  out  1  — upstream handshake.
- `s_axis_rq_tdata`  out  DATA_WIDTH — RQ data to the PCIe core.
- `s_axis_rq_tkeep`  out  KDW — per-DW keep.
- `s_axis_rq_tuser`  out  USER_WIDTH — RQ sideband (byte enables).
- `s_axis_rq_tlast`  out  1 — last beat of the request.
- `s_axis_rq_tvalid`  out  1 / `s_axis_rq_tready`  in  1 — core handshake.
- `rq_len_err`  out  1 — sticky error flag; cleared only by `rst`.

## Operation
- Accept = `rq_valid && rq_ready`. Output register load enable `ld = !s_axis_rq_tvalid || s_axis_rq_tready`.
- `rq_ready = ld && state != FLUSH`.
- States:
  - IDLE: expecting SOP.
  - BODY: mid-packet.
  - FLUSH: emit the residual 128 bits.
  - DROP: discard input beats until `rq_payload_last`.
- Header-only request: `rq_descriptor[78:75]` ∈ {0000, 0010} or N==0.
  - One output beat: data `{0, descriptor}`, keep = 4 low bits set, tlast=1.
  - Incoming payload bits are ignored. Stay in IDLE.
- Write request at SOP:
  - Latch N and expected beats `E = ceil(N/KDW)`.
  - Output `{payload[DATA_WIDTH-129:0], descriptor}`.
  - `saver <= payload[DATA_WIDTH-1:DATA_WIDTH-128]`.
- Body beats output `{payload[DATA_WIDTH-129:0], saver}` and update `saver`. A beat counter runs 1..E.
- Flush rule: `need_flush = ((N-1) mod KDW) >= KDW-4`.
  - The final input beat emits tlast = !need_flush.
  - If need_flush, the next cycle in FLUSH emits `{0, saver}` with tlast=1, then returns to IDLE.
- Tail keep: `r = (N+4) mod KDW`; keep = all-ones if r==0, else `(1<<r)-1`. Non-tail beats use all-ones.
- `tuser` on the first beat of each request:
  - first_be = `descriptor[111:108]`.
  - last_be = `descriptor[107:104]`, forced to 0000 when N==1.
  - All other bits 0. Later beats: `tuser` = 0.
- Packet ends on whichever comes first: the counted beat E, or `rq_payload_last`.
  - Last on beat k<E: set `rq_len_err`, close the packet using the latched N's keep rule.
  - Last missing on beat E: set `rq_len_err`, close normally, enter DROP. DROP accepts and discards beats through the one carrying last.
- SOP seen in BODY: set `rq_len_err`; treat the beat as a body beat.
- N > 1024: set `rq_len_err`; treat N as 1024.

## Timing
- Latency: 1 cycle from input accept to `s_axis_rq_tvalid`. The flush beat follows the last data beat by exactly 1 accepted output cycle.
- When `s_axis_rq_tvalid && !s_axis_rq_tready`:
  - All `s_axis_rq_*` outputs hold stable.
  - `rq_ready`=0; no state, saver, or counter change.
- Throughput: 1 beat/cycle with tready high. Back-to-back packets: SOP is accepted in the cycle after a non-flush last. With need_flush, one bubble on `rq_ready`.
- Reset: `s_axis_rq_tdata`=0, `tkeep`=0, `tuser`=0, `tlast`=0, `tvalid`=0, `rq_len_err`=0. State IDLE; saver and counters 0.
- Reset mid-packet abandons the packet. No further beats are emitted.

## Test plan
- 256-bit, read descriptor (type 0000), first_be F, last_be F:
  - One beat, keep 0x0F, tlast=1, tuser[3:0]=F, tuser[7:4]=F.
  - Accept is held with tready=0 for 3 cycles; output remains stable.
- 256-bit write, N=1:
  - Single beat, keep 0x1F, last_be forced 0.
  - N=4: one beat, keep 0xFF. N=5: two beats, keep 0xFF then 0x01. N=8: second beat keep 0x0F.
- 512-bit write, N=32 (2 input beats):
  - Output 3 beats (keep 0xFFFF, 0xFFFF, 0x000F); `rq_ready` low during FLUSH.
  - N=28: 2 beats, tail keep 0xFFFF.
- 256-bit write, N=20, random tready (50% low): payload DW ordering is intact across all beats, no beat is duplicated or lost, and the final keep is 0xFF.
- Length error, N=16 with `rq_payload_last` on beat 1:
  - `rq_len_err`=1, tlast on the beat carrying last.
  - A subsequent well-formed packet goes through correctly.
  - With last arriving on beat 4: two extra input beats are dropped.
- Reset asserted during BODY of N=24: all outputs 0 next cycle; a following N=2 packet emits a single beat with keep 0x3F.
